// File: rtl/game_pkg.sv
//==============================================================================
// Module : game_pkg
// Brief  : Shared types and constants for the Space Invaders game sequencer.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package game_pkg;

    localparam int          ARRAY_W   = 20;
    localparam int          ROW_W     = 4;
    localparam logic [19:0] FULL_WAVE = 20'h001FF;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        PLAY       = 3'd2,
        WAVE_CLEAR = 3'd3,
        LIFE_LOST  = 3'd4,
        GAME_OVER  = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/game_sequencer_if.sv
//==============================================================================
// Module : game_sequencer_if
// Brief  : Bus between the game sequencer and the player/invaders/renderer side.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface game_sequencer_if
    import game_pkg::*;
#(
    parameter int SCORE_W = 12
);
    logic                 i_start;
    logic                 i_hit;
    logic                 i_player_hit;
    logic [ARRAY_W-1:0]   i_invaders_array;
    logic [ROW_W-1:0]     i_invaders_row;
    logic                 o_invaders_reset;
    logic [2:0]           o_state;
    logic [SCORE_W-1:0]   o_score;
    logic [1:0]           o_lives;
    logic [3:0]           o_wave;
    logic                 o_game_over;

    modport master (
        input  i_start, i_hit, i_player_hit, i_invaders_array, i_invaders_row,
        output o_invaders_reset, o_state, o_score, o_lives, o_wave, o_game_over
    );

    modport slave (
        output i_start, i_hit, i_player_hit, i_invaders_array, i_invaders_row,
        input  o_invaders_reset, o_state, o_score, o_lives, o_wave, o_game_over
    );

endinterface

`default_nettype wire

// File: rtl/game_delay_counter.sv
//==============================================================================
// Module : game_delay_counter
// Brief  : Loadable down-counter; done while the count sits at zero.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module game_delay_counter #(
    parameter int WIDTH = 1
) (
    input  wire logic             i_clk,
    input  wire logic             i_reset_n,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_value,
    output logic                  o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
//==============================================================================
// Module : game_sequencer
// Brief  : Top-level game FSM: wave launch, score, lives, wave count, game over.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module game_sequencer
    import game_pkg::*;
#(
    parameter int LAUNCH_CYCLES = 25_000_000,
    parameter int CLEAR_CYCLES  = 50_000_000,
    parameter int DEATH_CYCLES  = 50_000_000,
    parameter int LIVES         = 3,
    parameter int LAND_ROW      = 14,
    parameter int SCORE_W       = 12
) (
    input  wire logic       i_clk_25MHz,
    input  wire logic       i_reset_n,
    game_sequencer_if.master bus
);

    localparam logic [2:0] c_st_idle       = 3'(IDLE);
    localparam logic [2:0] c_st_launch     = 3'(LAUNCH);
    localparam logic [2:0] c_st_play       = 3'(PLAY);
    localparam logic [2:0] c_st_wave_clear = 3'(WAVE_CLEAR);
    localparam logic [2:0] c_st_life_lost  = 3'(LIFE_LOST);
    localparam logic [2:0] c_st_game_over  = 3'(GAME_OVER);

    localparam int c_max_a = (LAUNCH_CYCLES > CLEAR_CYCLES) ? LAUNCH_CYCLES : CLEAR_CYCLES;
    localparam int c_max   = (c_max_a > DEATH_CYCLES) ? c_max_a : DEATH_CYCLES;
    localparam int c_cnt_w = (c_max < 2) ? 1 : $clog2(c_max);

    // Stored value is cycles-1 so a zero parameter still yields one cycle.
    localparam logic [c_cnt_w-1:0] c_launch_ld = (LAUNCH_CYCLES > 0) ? c_cnt_w'(LAUNCH_CYCLES - 1) : '0;
    localparam logic [c_cnt_w-1:0] c_clear_ld  = (CLEAR_CYCLES  > 0) ? c_cnt_w'(CLEAR_CYCLES  - 1) : '0;
    localparam logic [c_cnt_w-1:0] c_death_ld  = (DEATH_CYCLES  > 0) ? c_cnt_w'(DEATH_CYCLES  - 1) : '0;
    localparam logic [ROW_W-1:0]   c_land_row  = ROW_W'(LAND_ROW);
    localparam logic [1:0]         c_lives     = 2'(LIVES);

    logic [2:0]         r_state;
    logic               r_start_d;
    logic               r_hit_d;
    logic [SCORE_W-1:0] r_score;
    logic [1:0]         r_lives;
    logic [3:0]         r_wave;
    logic               r_invaders_reset;
    logic               r_game_over;

    logic [2:0]         w_next_state;
    logic [SCORE_W-1:0] w_next_score;
    logic [1:0]         w_next_lives;
    logic [3:0]         w_next_wave;
    logic               w_start_edge;
    logic               w_hit_edge;
    logic               w_load;
    logic [c_cnt_w-1:0] w_load_val;
    logic               w_done;

    assign w_start_edge = bus.i_start & ~r_start_d;
    assign w_hit_edge   = bus.i_hit   & ~r_hit_d;

    always_comb begin
        w_next_state = r_state;
        w_next_score = r_score;
        w_next_lives = r_lives;
        w_next_wave  = r_wave;
        case (r_state)
            c_st_idle, c_st_game_over: begin
                if (w_start_edge) begin
                    w_next_state = c_st_launch;
                    w_next_score = '0;
                    w_next_lives = c_lives;
                    w_next_wave  = 4'd1;
                end
            end
            c_st_launch: begin
                if (w_done) w_next_state = c_st_play;
            end
            c_st_play: begin
                if (w_hit_edge && (r_score != '1)) w_next_score = r_score + 1'b1;
                if (bus.i_invaders_row >= c_land_row) begin
                    w_next_state = c_st_game_over;
                    w_next_lives = 2'd0;
                end else if (bus.i_player_hit) begin
                    w_next_state = c_st_life_lost;
                    w_next_lives = r_lives - 2'd1;
                end else if (bus.i_invaders_array == '0) begin
                    w_next_state = c_st_wave_clear;
                end
            end
            c_st_wave_clear: begin
                if (w_done) begin
                    w_next_state = c_st_launch;
                    if (r_wave != 4'hF) w_next_wave = r_wave + 4'd1;
                end
            end
            c_st_life_lost: begin
                if (w_done) w_next_state = (r_lives != 2'd0) ? c_st_launch : c_st_game_over;
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // Every state entry is a state change, so the counter reloads on any transition.
    always_comb begin
        w_load     = (w_next_state != r_state);
        w_load_val = '0;
        case (w_next_state)
            c_st_launch:     w_load_val = c_launch_ld;
            c_st_wave_clear: w_load_val = c_clear_ld;
            c_st_life_lost:  w_load_val = c_death_ld;
            default:         w_load_val = '0;
        endcase
    end

    game_delay_counter #(
        .WIDTH (c_cnt_w)
    ) u_delay (
        .i_clk     (i_clk_25MHz),
        .i_reset_n (i_reset_n),
        .i_load    (w_load),
        .i_value   (w_load_val),
        .o_done    (w_done)
    );

    always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state          <= c_st_idle;
            r_start_d        <= 1'b0;
            r_hit_d          <= 1'b0;
            r_score          <= '0;
            r_lives          <= c_lives;
            r_wave           <= 4'd0;
            r_invaders_reset <= 1'b1;
            r_game_over      <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_start_d        <= bus.i_start;
            r_hit_d          <= bus.i_hit;
            r_score          <= w_next_score;
            r_lives          <= w_next_lives;
            r_wave           <= w_next_wave;
            r_invaders_reset <= (w_next_state != c_st_play);
            r_game_over      <= (w_next_state == c_st_game_over);
        end
    end

    assign bus.o_state          = r_state;
    assign bus.o_score          = r_score;
    assign bus.o_lives          = r_lives;
    assign bus.o_wave           = r_wave;
    assign bus.o_invaders_reset = r_invaders_reset;
    assign bus.o_game_over      = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
//==============================================================================
// Module : tb_game_sequencer
// Brief  : Scoreboard bench for game_sequencer against a behavioural game model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_game_sequencer;
    import game_pkg::*;

    localparam int CYC = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #20 clk = ~clk;

    game_sequencer_if #(.SCORE_W(12)) ifa ();
    game_sequencer_if #(.SCORE_W(2))  ifb ();

    assign ifb.i_start          = ifa.i_start;
    assign ifb.i_hit            = ifa.i_hit;
    assign ifb.i_player_hit     = ifa.i_player_hit;
    assign ifb.i_invaders_array = ifa.i_invaders_array;
    assign ifb.i_invaders_row   = ifa.i_invaders_row;

    game_sequencer #(
        .LAUNCH_CYCLES(CYC), .CLEAR_CYCLES(CYC), .DEATH_CYCLES(CYC),
        .LIVES(3), .LAND_ROW(14), .SCORE_W(12)
    ) u_dut_a (
        .i_clk_25MHz (clk),
        .i_reset_n   (rst_n),
        .bus         (ifa.master)
    );

    game_sequencer #(
        .LAUNCH_CYCLES(CYC), .CLEAR_CYCLES(CYC), .DEATH_CYCLES(CYC),
        .LIVES(3), .LAND_ROW(14), .SCORE_W(2)
    ) u_dut_b (
        .i_clk_25MHz (clk),
        .i_reset_n   (rst_n),
        .bus         (ifb.master)
    );

    int total = 0;
    int bad   = 0;

    // Reference game: phase, cycles remaining in the timed phase, and counters.
    state_e m_st;
    int     m_left, m_score, m_score2, m_lives, m_wave;
    bit     m_prev_start, m_prev_hit;

    logic [27:0] q[$];

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [27:0] model_vec();
        return {3'(m_st), 3'(m_st), (m_st != PLAY), 12'(m_score), 2'(m_score2),
                2'(m_lives), 4'(m_wave), (m_st == GAME_OVER)};
    endfunction

    function automatic logic [27:0] dut_vec();
        return {ifa.o_state, ifb.o_state, ifa.o_invaders_reset, ifa.o_score, ifb.o_score,
                ifa.o_lives, ifa.o_wave, ifa.o_game_over};
    endfunction

    task automatic model_reset();
        m_st = IDLE; m_left = 0; m_score = 0; m_score2 = 0;
        m_lives = 3; m_wave = 0; m_prev_start = 0; m_prev_hit = 0;
    endtask

    task automatic enter(state_e s);
        m_st   = s;
        m_left = CYC - 1;
    endtask

    task automatic model_step(bit s, bit h, bit p, logic [19:0] a, logic [3:0] r);
        bit se, he;
        se = s && !m_prev_start;
        he = h && !m_prev_hit;
        m_prev_start = s;
        m_prev_hit   = h;
        case (m_st)
            IDLE, GAME_OVER: if (se) begin
                m_score = 0; m_score2 = 0; m_lives = 3; m_wave = 1;
                enter(LAUNCH);
            end
            LAUNCH: if (m_left == 0) m_st = PLAY; else m_left--;
            PLAY: begin
                if (he) begin
                    m_score  = (m_score  < 4095) ? m_score + 1 : 4095;
                    m_score2 = (m_score2 < 3)    ? m_score2 + 1 : 3;
                end
                if (r >= 14) begin m_lives = 0; enter(GAME_OVER); end
                else if (p) begin m_lives = m_lives - 1; enter(LIFE_LOST); end
                else if (a == 0) enter(WAVE_CLEAR);
            end
            WAVE_CLEAR: if (m_left == 0) begin
                m_wave = (m_wave < 15) ? m_wave + 1 : 15;
                enter(LAUNCH);
            end else m_left--;
            LIFE_LOST: if (m_left == 0) begin
                if (m_lives != 0) enter(LAUNCH); else enter(GAME_OVER);
            end else m_left--;
            default: m_st = IDLE;
        endcase
    endtask

    task automatic drive(bit s, bit h, bit p, logic [19:0] a, logic [3:0] r);
        ifa.i_start          = s;
        ifa.i_hit            = h;
        ifa.i_player_hit     = p;
        ifa.i_invaders_array = a;
        ifa.i_invaders_row   = r;
        model_step(s, h, p, a, r);
        q.push_back(model_vec());
        @(posedge clk);
        #2;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 20'h001FF, 4'd1);
    endtask

    task automatic reset_now(string name);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk(name, 64'(dut_vec()), 64'(model_vec()));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        logic [27:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cycle_outputs", 64'(dut_vec()), 64'(e));
            end
        end
    end

    initial begin : stim
        rst_n                = 1'b0;
        ifa.i_start          = 1'b0;
        ifa.i_hit            = 1'b0;
        ifa.i_player_hit     = 1'b0;
        ifa.i_invaders_array = 20'h001FF;
        ifa.i_invaders_row   = 4'd1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_values", 64'(dut_vec()), 64'(model_vec()));
        rst_n = 1'b1;

        // Start game, launch into play.
        drive(1, 0, 0, 20'h001FF, 4'd1);
        idle(6);
        // Multi-cycle hit counts as one edge.
        drive(0, 1, 0, 20'h001FF, 4'd1);
        drive(0, 1, 0, 20'h001FF, 4'd1);
        drive(0, 1, 0, 20'h001FF, 4'd1);
        drive(0, 0, 0, 20'h001FF, 4'd1);
        drive(0, 1, 0, 20'h001FF, 4'd1);
        idle(2);
        // Hit edge coinciding with wave clear.
        drive(0, 1, 0, 20'h00000, 4'd3);
        idle(10);
        // Three deaths end the game.
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 20'h001FF, 4'd2);
            idle(10);
        end
        // Landing beats a simultaneous player hit.
        drive(1, 0, 0, 20'h001FF, 4'd1);
        idle(6);
        drive(0, 0, 1, 20'h001FF, 4'd14);
        idle(3);
        // Asynchronous reset in the middle of play.
        drive(1, 0, 0, 20'h001FF, 4'd1);
        idle(6);
        reset_now("async_reset_midplay");
        // Five hit edges saturate the narrow score.
        drive(1, 0, 0, 20'h001FF, 4'd1);
        idle(6);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 20'h001FF, 4'd1);
            drive(0, 0, 0, 20'h001FF, 4'd1);
        end
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            bit          s, h, p;
            logic [19:0] a;
            logic [3:0]  r;
            s = ($urandom_range(0, 19) == 0);
            h = $urandom_range(0, 1) != 0;
            p = ($urandom_range(0, 39) == 0);
            a = ($urandom_range(0, 49) == 0) ? 20'h0 : (20'($urandom) | 20'h1);
            r = ($urandom_range(0, 79) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom_range(0, 13));
            drive(s, h, p, a, r);
            if (n == 1500) reset_now("async_reset_random");
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
